// File: rtl/sub_arb.sv
// Round-robin arbiter sharing one 4-bit ripple-borrow subtractor among NREQ requesters.
// Optional build macro SUB_ARB_SAT_EN: saturate the difference on signed overflow.
module sub_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_diff,
    output logic                out_overflow,
    output logic [IDW-1:0]      out_id
);

    typedef enum logic {StEmpty, StFull} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [3:0]     diff_q, diff_d;
    logic           ovf_q, ovf_d;
    logic [IDW-1:0] id_q, id_d;

    logic           can_accept;
    logic           any_grant;
    logic [IDW-1:0] grant;
    logic [3:0]     op_a, op_b;
    logic [3:0]     sub_d, res;
    logic           sub_ovf;

    assign can_accept = (state_q == StEmpty) || out_ready;

    // First valid requester scanning upward from ptr, wrapping at NREQ-1.
    always_comb begin
        int unsigned idx;
        any_grant = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_grant && req_valid[idx]) begin
                any_grant = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && can_accept && any_grant) req_ready[grant] = 1'b1;
    end

    assign op_a = req_a[4*grant +: 4];
    assign op_b = req_b[4*grant +: 4];

    always_comb begin
        logic br;
        br    = 1'b0;
        sub_d = '0;
        for (int i = 0; i < 4; i++) begin
            sub_d[i] = op_a[i] ^ op_b[i] ^ br;
            br       = (~op_a[i] & op_b[i]) | ((~op_a[i] | op_b[i]) & br);
        end
        sub_ovf = (op_a[3] ^ op_b[3]) & (sub_d[3] ^ op_a[3]);
    end

`ifdef SUB_ARB_SAT_EN
    assign res = sub_ovf ? (op_a[3] ? 4'b1000 : 4'b0111) : sub_d;
`else
    assign res = sub_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        diff_d  = diff_q;
        ovf_d   = ovf_q;
        id_d    = id_q;
        if (can_accept) begin
            if (any_grant) begin
                state_d = StFull;
                diff_d  = res;
                ovf_d   = sub_ovf;
                id_d    = grant;
                ptr_d   = (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
            end else begin
                state_d = StEmpty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            diff_q  <= '0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            diff_q  <= diff_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
        end
    end

    assign out_valid    = (state_q == StFull);
    assign out_diff     = diff_q;
    assign out_overflow = ovf_q;
    assign out_id       = id_q;

endmodule

// File: doc/sub_arb.md
# sub_arb

Round-robin arbiter and sequencer sharing one 4-bit two's-complement subtractor among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per accepted cycle, computes `a - b` with a signed overflow flag, and returns the result with the winner's ID through a registered valid/ready output stage. It sits between the requesting engines and the shared arithmetic resource.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of the requester ID; must satisfy `2**IDW >= NREQ`.

- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `req_valid`: input, `NREQ` bits. Per-requester operand valid.
- `req_a`: input, `4*NREQ` bits. Minuend; requester i occupies bits `[4i+3:4i]`.
- `req_b`: input, `4*NREQ` bits. Subtrahend; same packing as `req_a`.
- `req_ready`: output, `NREQ` bits. One-hot or zero; a bit is set only for the granted requester in its accept cycle.
- `out_valid`: output, 1 bit. Result valid.
- `out_ready`: input, 1 bit. Downstream accepts the result.
- `out_diff`: output, 4 bits. `a - b`, modulo 16.
- `out_overflow`: output, 1 bit. Signed overflow flag.
- `out_id`: output, `IDW` bits. Index of the requester that owns the result.

## Operation
- **Arithmetic:** ripple-borrow subtract, bit-serial in one combinational pass.
  - `d[i] = a[i] ^ b[i] ^ br`, starting with `br = 0`.
  - `br' = (~a[i] & b[i]) | ((~a[i] | b[i]) & br)`.
  - `overflow = (a[3] ^ b[3]) & (d[3] ^ a[3])`.
- **Accept condition:** `can_accept = !out_valid | out_ready`.
- **Grant:** when `can_accept` is 1 and any `req_valid` is set, the grant goes to the first valid requester scanning upward from `ptr`, wrapping at `NREQ-1` to 0.
  - `req_ready[g]` is 1 in that cycle only. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, `ptr` and `can_accept`.
  - `req_valid` never depends on `req_ready`, so there is no combinational loop.
- **Transfer:** occurs when `req_valid[g] & req_ready[g]`. On the next edge:
  - `out_diff`, `out_overflow` and `out_id = g` are registered.
  - `out_valid` is set to 1.
  - `ptr` becomes `(g+1) mod NREQ`.
- **States:**
  - EMPTY (`out_valid=0`): accept when any request is valid, then go to FULL.
  - FULL (`out_valid=1`), `out_ready=0`: hold all outputs stable and grant nobody.
  - FULL, `out_ready=1` with a request: accept the new request in the same cycle and stay FULL. No bubble.
  - FULL, `out_ready=1` with no request: go to EMPTY.
- `ptr` changes only on a transfer.
- If `req_valid` drops without a grant, that requester is simply not considered. Nothing is latched.
- **Reset** (synchronous, overrides everything in the same edge, including mid-transfer): `out_valid=0`, `out_diff=0`, `out_overflow=0`, `out_id=0`, `ptr=0`. Any result pending at reset is discarded.
- `req_ready` is 0 while `rst` is high.

## Timing
- Latency: 1 cycle from the transfer edge to `out_valid`.
- Throughput: 1 result per cycle while `out_ready` is held high.
- All outputs except `req_ready` are registered. `req_ready` is combinational, with a path through the NREQ-wide priority rotate.
- The subtractor sits in the path from request to output register. The critical path is 4 borrow stages plus the NREQ:1 operand mux.

## Configuration
- **`SUB_ARB_SAT_EN` defined:** saturate on overflow.
  - If overflow is 1, `out_diff = a[3] ? 4'b1000 : 4'b0111`.
  - `out_overflow` still reports 1.
- **`SUB_ARB_SAT_EN` undefined:** `out_diff` is the wrapped modulo-16 result.

## Test plan
- **Reset and single request:** hold `rst` 2 cycles, then assert `req_valid=4'b0001` with `a=5`, `b=3`.
  - `req_ready=4'b0001` in that cycle.
  - Next cycle: `out_valid=1`, `out_diff=2`, `out_overflow=0`, `out_id=0`.
- **Overflow:** requester 2 sends `a=4'b0100`, `b=4'b1011` (4 - (-5)).
  - Result: `out_overflow=1`, `out_id=2`.
  - `out_diff=4'b1001` without `SUB_ARB_SAT_EN`; `4'b0111` with it.
  - Also check `a=4'b1000`, `b=1`: overflow=1, `out_diff=4'b0111` (wrap) or `4'b1000` (saturated).
- **Round-robin fairness:** all four `req_valid` held high, `out_ready=1`.
  - Grants run 0,1,2,3,0,1 on consecutive cycles.
  - Each `out_id` matches, one result per cycle.
- **Backpressure:** `out_ready=0` for 3 cycles with result 7 pending and requests valid.
  - `out_*` stays stable and `req_ready=0`.
  - In the cycle `out_ready` rises, the next requester is granted in the same cycle.
- **Sparse wrap:** `ptr=3`, only requesters 1 and 2 valid.
  - Grant 1, then 2, then 1.
- **Reset mid-operation:** `rst` asserted in a transfer cycle with `out_valid=1`.
  - Next cycle: `out_valid=0`, `out_diff=0`, `ptr=0`.
  - The first grant after reset goes to the lowest valid index.
